l1_trigger_buffer_mgr: RTL and testbench

//  Consumes the one-cycle clk33 L1 pulse produced by the L1 stretcher/synchronizer stage and allocates
//  it to one of NBUF event buffers. Enforces a post-trigger holdoff, assigns a monotonically increasing

---
 rtl/l1_trigger_buffer_mgr.sv | 199 +++++++++++++++++++
 tb/tb_l1_trigger_buffer_mgr.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/l1_trigger_buffer_mgr.sv
// -----------------------------------------------------------------------------
// l1_trigger_buffer_mgr
//
// Takes the one-cycle clk33 L1 pulse from the stretcher/synchronizer stage and
// allocates each accepted trigger to one of NBUF event buffers, arranged as a
// circular queue. After each accepted trigger, a holdoff window ignores
// further L1 pulses. Each accepted trigger is stamped with an incrementing
// trigger number. Occupied buffers are handed to readout oldest first over a
// valid/ack handshake. Triggers that arrive while every buffer is occupied are
// counted in a saturating drop counter, and busy flags that all buffers are
// occupied.
//
// Ports
//   clk33        in   1            33 MHz clock, the only clock
//   rst          in   1            synchronous, active-high reset
//   L1_pulsed    in   1            one-cycle L1 pulse
//   enable       in   1            1 = accept triggers, 0 = ignore L1
//   rd_valid     out  1            at least one buffer holds an unread event
//   rd_buf       out  PTR_W        index of the oldest unread buffer
//   rd_trig_num  out  TRIG_CNT_W   trigger number stored with rd_buf
//   rd_ack       in   1            readout of rd_buf complete, frees it
//   busy         out  1            all NBUF buffers occupied
//   trig_count   out  TRIG_CNT_W   number of accepted triggers
//   drop_count   out  DROP_CNT_W   triggers lost to full buffers (saturating)
// -----------------------------------------------------------------------------
module l1_trigger_buffer_mgr #(
  parameter int NBUF       = 4,
  parameter int TRIG_CNT_W = 32,
  parameter int HOLDOFF    = 8,
  parameter int DROP_CNT_W = 16
) (
  input  logic                          clk33,
  input  logic                          rst,
  input  logic                          L1_pulsed,
  input  logic                          enable,
  output logic                          rd_valid,
  output logic [$clog2(NBUF)-1:0]       rd_buf,
  output logic [TRIG_CNT_W-1:0]         rd_trig_num,
  input  logic                          rd_ack,
  output logic                          busy,
  output logic [TRIG_CNT_W-1:0]         trig_count,
  output logic [DROP_CNT_W-1:0]         drop_count
);

  localparam int PTR_W = $clog2(NBUF);
  localparam int OCC_W = PTR_W + 1;
  localparam int HO_W  = 8;

  localparam logic [OCC_W-1:0]      OCC_FULL  = OCC_W'(NBUF);
  localparam logic [OCC_W-1:0]      OCC_EMPTY = {OCC_W{1'b0}};
  localparam logic [HO_W-1:0]       HO_LOAD   = HO_W'(HOLDOFF - 1);
  localparam logic [HO_W-1:0]       HO_ZERO   = {HO_W{1'b0}};
  localparam logic [DROP_CNT_W-1:0] DROP_MAX  = {DROP_CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } ho_state_e;

  ho_state_e              state_q, state_d;
  logic [HO_W-1:0]        hold_cnt_q, hold_cnt_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]       occ_q, occ_d;
  logic [TRIG_CNT_W-1:0]  slot_q [NBUF];
  logic [TRIG_CNT_W-1:0]  slot_d [NBUF];
  logic [TRIG_CNT_W-1:0]  trig_cnt_q, trig_cnt_d;
  logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   busy_q, busy_d;
  logic [TRIG_CNT_W-1:0]  rd_trig_q, rd_trig_d;

  logic                   l1_live_s;
  logic                   accept_s;
  logic                   drop_s;
  logic                   ack_s;

  // Trigger/readout qualification on pre-edge state. Fullness is judged
  // before any same-cycle ack, so full + L1 + ack still drops the trigger.
  always_comb begin
    l1_live_s = L1_pulsed & enable & (state_q == ST_IDLE);
    accept_s  = l1_live_s & (occ_q != OCC_FULL);
    drop_s    = l1_live_s & (occ_q == OCC_FULL);
    ack_s     = rd_ack & (occ_q != OCC_EMPTY);
  end

  // Next-state logic for holdoff FSM, buffer queue, counters and outputs.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    trig_cnt_d = trig_cnt_q;
    drop_cnt_d = drop_cnt_q;
    for (int i = 0; i < NBUF; i++) begin
      slot_d[i] = slot_q[i];
    end

    // Holdoff: the counter loaded with HOLDOFF-1 gives exactly HOLDOFF
    // rejecting cycles, because the cycle in which it reaches zero still
    // rejects and only the following cycle is back in IDLE.
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d    = ST_HOLD;
          hold_cnt_d = HO_LOAD;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == HO_ZERO) begin
          state_d    = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - HO_W'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        hold_cnt_d = HO_ZERO;
      end
    endcase

    if (accept_s) begin
      slot_d[wr_ptr_q] = trig_cnt_q;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      trig_cnt_d       = trig_cnt_q + TRIG_CNT_W'(1);
    end else begin
      wr_ptr_d         = wr_ptr_q;
    end

    if (ack_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Simultaneous accept and ack leaves occupancy unchanged.
    case ({accept_s, ack_s})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    if (drop_s && (drop_cnt_q != DROP_MAX)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end

    // Outputs are precomputed from next state so they are registered yet
    // reflect the post-edge queue (including a slot written this cycle).
    rd_valid_d = (occ_d != OCC_EMPTY);
    busy_d     = (occ_d == OCC_FULL);
    rd_trig_d  = slot_d[rd_ptr_d];
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk33) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= HO_ZERO;
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      occ_q      <= OCC_EMPTY;
      trig_cnt_q <= {TRIG_CNT_W{1'b0}};
      drop_cnt_q <= {DROP_CNT_W{1'b0}};
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      rd_trig_q  <= {TRIG_CNT_W{1'b0}};
      for (int i = 0; i < NBUF; i++) begin
        slot_q[i] <= {TRIG_CNT_W{1'b0}};
      end
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      trig_cnt_q <= trig_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      rd_trig_q  <= rd_trig_d;
      for (int i = 0; i < NBUF; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign rd_valid    = rd_valid_q;
  assign rd_buf      = rd_ptr_q;
  assign rd_trig_num = rd_trig_q;
  assign busy        = busy_q;
  assign trig_count  = trig_cnt_q;
  assign drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_l1_trigger_buffer_mgr.sv
// -----------------------------------------------------------------------------
// tb_l1_trigger_buffer_mgr
//
// Directed bench for l1_trigger_buffer_mgr (NBUF=4, HOLDOFF=8). A table of
// one-cycle vectors covers reset, single trigger/readout and the holdoff
// window. Hand-written sequences cover full buffers, drops, pointer wrap,
// simultaneous accept+ack, enable=0 and reset in the middle of a stream.
// -----------------------------------------------------------------------------
module tb_l1_trigger_buffer_mgr;

  logic        clk33 = 1'b0;
  logic        rst = 1'b1;
  logic        L1_pulsed = 1'b0;
  logic        enable = 1'b0;
  logic        rd_ack = 1'b0;
  logic        rd_valid;
  logic [1:0]  rd_buf;
  logic [31:0] rd_trig_num;
  logic        busy;
  logic [31:0] trig_count;
  logic [15:0] drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  l1_trigger_buffer_mgr #(
    .NBUF(4), .TRIG_CNT_W(32), .HOLDOFF(8), .DROP_CNT_W(16)
  ) dut (
    .clk33(clk33), .rst(rst), .L1_pulsed(L1_pulsed), .enable(enable),
    .rd_valid(rd_valid), .rd_buf(rd_buf), .rd_trig_num(rd_trig_num),
    .rd_ack(rd_ack), .busy(busy), .trig_count(trig_count),
    .drop_count(drop_count)
  );

  always #5 clk33 = ~clk33;

  typedef struct {
    bit          rst;
    bit          l1;
    bit          en;
    bit          ack;
    bit          exp_valid;
    logic [1:0]  exp_buf;
    logic [31:0] exp_trig;
    bit          exp_busy;
    logic [31:0] exp_tc;
    logic [15:0] exp_dc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit l, bit e, bit a, bit v, logic [1:0] b,
                              logic [31:0] t, bit bz, logic [31:0] tc,
                              logic [15:0] dc);
    vec_t x;
    x.rst = r; x.l1 = l; x.en = e; x.ack = a;
    x.exp_valid = v; x.exp_buf = b; x.exp_trig = t; x.exp_busy = bz;
    x.exp_tc = tc; x.exp_dc = dc;
    return x;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(string tag, bit v, logic [1:0] b, logic [31:0] t,
                           bit bz, logic [31:0] tc, logic [15:0] dc);
    check({tag, ".rd_valid"},    32'(rd_valid),   32'(v));
    check({tag, ".rd_buf"},      32'(rd_buf),     32'(b));
    check({tag, ".rd_trig_num"}, rd_trig_num,     t);
    check({tag, ".busy"},        32'(busy),       32'(bz));
    check({tag, ".trig_count"},  trig_count,      tc);
    check({tag, ".drop_count"},  32'(drop_count), 32'(dc));
  endtask

  // One clock cycle: drive on the falling edge, sample 1 ns after rising edge.
  task automatic cyc(bit r, bit l, bit e, bit a);
    @(negedge clk33);
    rst = r; L1_pulsed = l; enable = e; rd_ack = a;
    @(posedge clk33);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    // ---- table: reset, single trigger/readout, holdoff window ----
    //                r  l  e  a   v  buf trig bz tc dc
    vecs.push_back(mk(1, 0, 1, 0,  0, 0, 0, 0, 0, 0));   // reset state
    vecs.push_back(mk(0, 1, 1, 0,  1, 0, 0, 0, 1, 0));   // first trigger -> #0
    vecs.push_back(mk(0, 0, 1, 1,  0, 1, 0, 0, 1, 0));   // ack -> empty
    vecs.push_back(mk(1, 0, 1, 0,  0, 0, 0, 0, 0, 0));   // reset again
    vecs.push_back(mk(0, 1, 1, 0,  1, 0, 0, 0, 1, 0));   // cycle 0 accept
    for (int i = 1; i <= 7; i++)
      vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 1, 0));  // cycles 1..7
    vecs.push_back(mk(0, 1, 1, 0,  1, 0, 0, 0, 1, 0));   // cycle 8 ignored
    vecs.push_back(mk(0, 1, 1, 0,  1, 0, 0, 0, 2, 0));   // cycle 9 accepted
    vecs.push_back(mk(0, 0, 1, 1,  1, 1, 1, 0, 2, 0));   // buf1 holds #1
    vecs.push_back(mk(0, 0, 1, 1,  0, 2, 0, 0, 2, 0));   // drained
    vecs.push_back(mk(0, 0, 1, 1,  0, 2, 0, 0, 2, 0));   // ack on empty ignored

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].l1, vecs[i].en, vecs[i].ack);
      check_all($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_buf,
                vecs[i].exp_trig, vecs[i].exp_busy, vecs[i].exp_tc,
                vecs[i].exp_dc);
    end

    // ---- fill 4 buffers, 5th pulse dropped ----
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      if (k < 4) begin
        check_all($sformatf("fill%0d", k), 1'b1, 2'd0, 32'd0, (k == 3),
                  32'(k + 1), 16'd0);
        idle(9);
      end else begin
        check_all("fill_drop", 1'b1, 2'd0, 32'd0, 1'b1, 32'd4, 16'd1);
      end
    end

    // Next cycle: still full, no holdoff from the drop -> L1 dropped again,
    // while the same-cycle ack frees buf0.
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    check_all("full_l1_ack", 1'b1, 2'd1, 32'd1, 1'b0, 32'd4, 16'd2);

    // Accept into wrapped buf0 gets trigger #4.
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check_all("wrap_accept", 1'b1, 2'd1, 32'd1, 1'b1, 32'd5, 16'd2);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check_all("drain_b2", 1'b1, 2'd2, 32'd2, 1'b0, 32'd5, 16'd2);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check_all("drain_b3", 1'b1, 2'd3, 32'd3, 1'b0, 32'd5, 16'd2);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check_all("drain_b0", 1'b1, 2'd0, 32'd4, 1'b0, 32'd5, 16'd2);

    // ---- occupancy 1: accept and ack in the same cycle ----
    idle(10);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    check_all("acc_and_ack", 1'b1, 2'd1, 32'd5, 1'b0, 32'd6, 16'd2);

    // ---- enable=0: L1 ignored, readout still drains ----
    idle(10);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check_all("dis_l1", 1'b1, 2'd1, 32'd5, 1'b0, 32'd6, 16'd2);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check_all("dis_drain", 1'b0, 2'd2, 32'd2, 1'b0, 32'd6, 16'd2);

    // ---- three occupied, then reset mid-stream ----
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    idle(9);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    idle(9);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check_all("three_occ", 1'b1, 2'd2, 32'd6, 1'b0, 32'd9, 16'd2);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    check_all("mid_reset", 1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 16'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check_all("post_reset", 1'b1, 2'd0, 32'd0, 1'b0, 32'd1, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
